// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared constants, FSM states and range helper for the nonce dispatcher
//
// Purpose : common definitions imported by nonce_dispatcher.
// Contents: NONCE_W, state_e (IDLE/DISPATCH/RUN/DRAIN), range_count().
package miner_pkg;

  localparam int NONCE_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // Number of fixed-size ranges the 32-bit nonce space splits into.
  function automatic int unsigned range_count(input int unsigned range_log2);
    return 32'd1 << (32 - range_log2);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way round-robin arbiter with one-hot grant and advance enable
//
// Purpose : grants one requester; priority rotates past the last winner when adv_i is high.
// Ports   : clk_i, rst_ni    - clock, asynchronous active-low reset
//           clear_i          - return priority to requester 0
//           req_i[N]         - request vector
//           adv_i            - the current grant is consumed; rotate priority
//           gnt_o[N]         - one-hot grant (combinational)
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  // Scan from the highest offset down so the requester closest to ptr_q wins.
  always_comb begin
    int            pos;
    int            nxt;
    logic [PW-1:0] idx;
    gnt_o = '0;
    ptr_d = ptr_q;
    pos   = 0;
    nxt   = 0;
    idx   = '0;
    for (int off = N - 1; off >= 0; off--) begin
      pos = int'(ptr_q) + off;
      if (pos >= N) pos = pos - N;
      idx = PW'(pos);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        nxt        = (pos + 1 >= N) ? 0 : pos + 1;
        ptr_d      = PW'(nxt);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (clear_i) begin
      ptr_q <= '0;
    end else if (adv_i && (|req_i)) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/nonce_dispatcher.sv
// rtl/nonce_dispatcher.sv - splits the nonce space across hash cores and collects golden nonces
//
// Purpose : hands each idle core the next nonce range, reloads cores as they finish,
//           and funnels found nonces through a round-robin arbiter to one result register.
// Ports   : clk, reset (async, active-low)
//           job_start, job_abort          - host job control pulses
//           busy, exhausted, overflow     - job status (exhausted/overflow sticky)
//           core_load, core_base, core_stop - per-core range dispatch
//           core_done, core_found, core_nonce - per-core reports
//           res_valid, res_nonce, res_core, res_ready - result handshake to host
module nonce_dispatcher
  import miner_pkg::*;
#(
  parameter int N_CORES      = 2,
  parameter int RANGE_LOG2   = 24,
  parameter int STOP_ON_FIND = 1,
  localparam int CW          = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       job_start,
  input  logic                       job_abort,
  output logic                       busy,
  output logic                       exhausted,
  output logic                       overflow,
  output logic [N_CORES-1:0]         core_load,
  output logic [32*N_CORES-1:0]      core_base,
  output logic [N_CORES-1:0]         core_stop,
  input  logic [N_CORES-1:0]         core_done,
  input  logic [N_CORES-1:0]         core_found,
  input  logic [32*N_CORES-1:0]      core_nonce,
  output logic                       res_valid,
  output logic [31:0]                res_nonce,
  output logic [CW-1:0]              res_core,
  input  logic                       res_ready
);

  localparam int          CNT_W    = 33 - RANGE_LOG2;
  localparam int unsigned N_RANGES = range_count(RANGE_LOG2);

  state_e                     state_q;
  logic [CNT_W-1:0]           range_q;
  logic [CW-1:0]              disp_q;
  logic [N_CORES-1:0]         stop_q, load_q, reload_q, pend_q;
  logic [NONCE_W*N_CORES-1:0] base_q, pend_nonce_q;
  logic                       res_valid_q, exhausted_q, overflow_q;
  logic [NONCE_W-1:0]         res_nonce_q;
  logic [CW-1:0]              res_core_q;

  logic                       no_range, last_range, start_acc, abort_acc, halt, load_out;
  logic [NONCE_W-1:0]         cur_base, ld_base, gnt_nonce;
  logic [N_CORES-1:0]         done_v, found_v, req_rl, pick, disp_oh, ld_vec, gnt, gnt_take;
  logic [CW-1:0]              gnt_idx;

  // The range counter's top bit is the carry-out: set once every range is handed out.
  assign no_range   = range_q[CNT_W-1];
  assign last_range = (range_q == CNT_W'(N_RANGES - 1));
  assign cur_base   = {range_q[CNT_W-2:0], {RANGE_LOG2{1'b0}}};
  assign ld_base    = start_acc ? '0 : cur_base;

  assign done_v    = core_done & ~stop_q;
  assign found_v   = core_found & ~stop_q;
  assign req_rl    = reload_q | done_v;
  assign start_acc = (state_q == ST_IDLE) && job_start && !job_abort;
  assign abort_acc = (state_q != ST_IDLE) && job_abort;
  assign halt      = (STOP_ON_FIND != 0) && (|found_v);
  assign load_out  = (|pend_q) && (!res_valid_q || res_ready) && !start_acc && !abort_acc;
  assign gnt_take  = load_out ? gnt : '0;

  always_comb begin
    pick      = '0;
    disp_oh   = '0;
    gnt_idx   = '0;
    gnt_nonce = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (req_rl[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
    for (int i = 0; i < N_CORES; i++) begin
      disp_oh[i] = (disp_q == CW'(i));
      if (gnt[i]) begin
        gnt_idx   = CW'(i);
        gnt_nonce = pend_nonce_q[i*NONCE_W +: NONCE_W];
      end
    end
  end

  // Which core (if any) receives a new range this cycle.
  always_comb begin
    ld_vec = '0;
    case (state_q)
      ST_IDLE:     if (start_acc) ld_vec[0] = 1'b1;
      ST_DISPATCH: if (!abort_acc && !halt) ld_vec = disp_oh;
      ST_RUN:      if (!abort_acc && !halt && !no_range) ld_vec = pick;
      default:     ld_vec = '0;
    endcase
  end

  rr_arbiter #(.N(N_CORES)) u_arb (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (start_acc),
    .req_i   (pend_q),
    .adv_i   (load_out),
    .gnt_o   (gnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      range_q      <= '0;
      disp_q       <= '0;
      stop_q       <= '1;
      load_q       <= '0;
      reload_q     <= '0;
      base_q       <= '0;
      pend_q       <= '0;
      pend_nonce_q <= '0;
      res_valid_q  <= 1'b0;
      res_nonce_q  <= '0;
      res_core_q   <= '0;
      exhausted_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      // Range dispatch
      load_q <= ld_vec;
      for (int i = 0; i < N_CORES; i++) begin
        if (ld_vec[i]) base_q[i*NONCE_W +: NONCE_W] <= ld_base;
      end
      if (start_acc)    range_q <= CNT_W'(1);
      else if (|ld_vec) range_q <= range_q + CNT_W'(1);

      if (abort_acc || halt)                     stop_q <= '1;
      else if (state_q == ST_RUN && no_range)    stop_q <= stop_q | pick;
      else                                       stop_q <= stop_q & ~ld_vec;

      if (state_q == ST_IDLE || abort_acc || halt) reload_q <= '0;
      else if (state_q == ST_RUN)                  reload_q <= req_rl & ~pick;
      else                                         reload_q <= req_rl;

      // Result capture; a find against an occupied slot is dropped.
      if (start_acc || abort_acc) begin
        pend_q <= '0;
      end else begin
        pend_q <= (pend_q & ~gnt_take) | (found_v & ~pend_q);
      end
      for (int i = 0; i < N_CORES; i++) begin
        if (found_v[i] && !pend_q[i]) pend_nonce_q[i*NONCE_W +: NONCE_W] <= core_nonce[i*NONCE_W +: NONCE_W];
      end
      if (start_acc)                  overflow_q <= 1'b0;
      else if (|(found_v & pend_q))   overflow_q <= 1'b1;

      if (abort_acc) begin
        res_valid_q <= 1'b0;
      end else if (load_out) begin
        res_valid_q <= 1'b1;
        res_nonce_q <= gnt_nonce;
        res_core_q  <= gnt_idx;
      end else if (res_ready) begin
        res_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (start_acc) begin
            exhausted_q <= 1'b0;
            disp_q      <= CW'(1);
            state_q     <= (N_CORES == 1) ? ST_RUN : ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          if (abort_acc) state_q <= ST_IDLE;
          else if (halt) state_q <= ST_DRAIN;
          else begin
            disp_q <= disp_q + CW'(1);
            if (disp_q == CW'(N_CORES - 1) || last_range) state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort_acc) state_q <= ST_IDLE;
          else if (halt) state_q <= ST_DRAIN;
          else if (no_range && (&(stop_q | pick))) begin
            exhausted_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          if (abort_acc || (pend_q == '0 && (!res_valid_q || res_ready))) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign exhausted = exhausted_q;
  assign overflow  = overflow_q;
  assign core_load = load_q;
  assign core_base = base_q;
  assign core_stop = stop_q;
  assign res_valid = res_valid_q;
  assign res_nonce = res_nonce_q;
  assign res_core  = res_core_q;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// tb/tb_nonce_dispatcher.sv - directed self-checking bench for nonce_dispatcher
module tb_nonce_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_start = 1'b0, job_abort = 1'b0, res_ready = 1'b0;
  logic [1:0]  core_done = '0, core_found = '0;
  logic [63:0] core_nonce = '0;

  logic        busy_a, exhausted_a, overflow_a, res_valid_a;
  logic [1:0]  core_load_a, core_stop_a;
  logic [63:0] core_base_a;
  logic [31:0] res_nonce_a;
  logic [0:0]  res_core_a;

  logic        busy_b, exhausted_b, overflow_b, res_valid_b;
  logic [1:0]  core_load_b, core_stop_b;
  logic [63:0] core_base_b;
  logic [31:0] res_nonce_b;
  logic [0:0]  res_core_b;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nonce_dispatcher #(.N_CORES(2), .RANGE_LOG2(30), .STOP_ON_FIND(1)) dut_a (
    .clk(clk), .reset(rst_n), .job_start(job_start), .job_abort(job_abort),
    .busy(busy_a), .exhausted(exhausted_a), .overflow(overflow_a),
    .core_load(core_load_a), .core_base(core_base_a), .core_stop(core_stop_a),
    .core_done(core_done), .core_found(core_found), .core_nonce(core_nonce),
    .res_valid(res_valid_a), .res_nonce(res_nonce_a), .res_core(res_core_a), .res_ready(res_ready)
  );

  nonce_dispatcher #(.N_CORES(2), .RANGE_LOG2(30), .STOP_ON_FIND(0)) dut_b (
    .clk(clk), .reset(rst_n), .job_start(job_start), .job_abort(job_abort),
    .busy(busy_b), .exhausted(exhausted_b), .overflow(overflow_b),
    .core_load(core_load_b), .core_base(core_base_b), .core_stop(core_stop_b),
    .core_done(core_done), .core_found(core_found), .core_nonce(core_nonce),
    .res_valid(res_valid_b), .res_nonce(res_nonce_b), .res_core(res_core_b), .res_ready(res_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    job_start = 0; job_abort = 0; res_ready = 0; core_done = '0; core_found = '0; core_nonce = '0;
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  // Starts a job and advances to the RUN state (both cores loaded).
  task automatic start_job();
    job_start = 1; tick(); job_start = 0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(); tick();
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy_a); end
    n_checks++; if (exhausted_a !== 1'b0) begin n_fail++; $display("FAIL rst_exh got %b want 0", exhausted_a); end
    n_checks++; if (overflow_a !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b want 0", overflow_a); end
    n_checks++; if (core_load_a !== 2'b00) begin n_fail++; $display("FAIL rst_load got %b want 00", core_load_a); end
    n_checks++; if (core_base_a !== 64'h0) begin n_fail++; $display("FAIL rst_base got %h want 0", core_base_a); end
    n_checks++; if (core_stop_a !== 2'b11) begin n_fail++; $display("FAIL rst_stop got %b want 11", core_stop_a); end
    n_checks++; if (res_valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got %b want 0", res_valid_a); end
    n_checks++; if (res_nonce_a !== 32'h0) begin n_fail++; $display("FAIL rst_rnonce got %h want 0", res_nonce_a); end
    n_checks++; if (res_core_a !== 1'b0) begin n_fail++; $display("FAIL rst_rcore got %b want 0", res_core_a); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_dispatch();
    job_start = 1; tick(); job_start = 0;
    n_checks++; if (core_load_a !== 2'b01) begin n_fail++; $display("FAIL disp_load0 got %b want 01", core_load_a); end
    n_checks++; if (core_base_a[31:0] !== 32'h0) begin n_fail++; $display("FAIL disp_base0 got %h want 00000000", core_base_a[31:0]); end
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL disp_busy got %b want 1", busy_a); end
    tick();
    n_checks++; if (core_load_a !== 2'b10) begin n_fail++; $display("FAIL disp_load1 got %b want 10", core_load_a); end
    n_checks++; if (core_base_a[63:32] !== 32'h40000000) begin n_fail++; $display("FAIL disp_base1 got %h want 40000000", core_base_a[63:32]); end
    n_checks++; if (core_stop_a !== 2'b00) begin n_fail++; $display("FAIL disp_stop got %b want 00", core_stop_a); end
  endtask

  task automatic test_reload_exhaust();
    core_done = 2'b01; tick();
    n_checks++; if (core_load_a !== 2'b01) begin n_fail++; $display("FAIL rl_load0 got %b want 01", core_load_a); end
    n_checks++; if (core_base_a[31:0] !== 32'h80000000) begin n_fail++; $display("FAIL rl_base0 got %h want 80000000", core_base_a[31:0]); end
    core_done = 2'b10; tick();
    n_checks++; if (core_load_a !== 2'b10) begin n_fail++; $display("FAIL rl_load1 got %b want 10", core_load_a); end
    n_checks++; if (core_base_a[63:32] !== 32'hC0000000) begin n_fail++; $display("FAIL rl_base1 got %h want C0000000", core_base_a[63:32]); end
    core_done = 2'b00; tick();
    core_done = 2'b11; tick(); core_done = 2'b00;
    n_checks++; if (core_load_a !== 2'b00) begin n_fail++; $display("FAIL ex_noload got %b want 00", core_load_a); end
    n_checks++; if (core_stop_a !== 2'b01) begin n_fail++; $display("FAIL ex_stop_mid got %b want 01", core_stop_a); end
    tick();
    n_checks++; if (core_load_a !== 2'b00) begin n_fail++; $display("FAIL ex_noload2 got %b want 00", core_load_a); end
    n_checks++; if (core_stop_a !== 2'b11) begin n_fail++; $display("FAIL ex_stop got %b want 11", core_stop_a); end
    n_checks++; if (exhausted_a !== 1'b1) begin n_fail++; $display("FAIL ex_exh got %b want 1", exhausted_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL ex_busy got %b want 0", busy_a); end
  endtask

  task automatic test_stop_on_find();
    do_reset();
    start_job();
    core_found = 2'b10; core_nonce = {32'h4000ABCD, 32'h0}; tick();
    n_checks++; if (core_stop_a !== 2'b11) begin n_fail++; $display("FAIL sof_stop got %b want 11", core_stop_a); end
    n_checks++; if (res_valid_a !== 1'b0) begin n_fail++; $display("FAIL sof_early got %b want 0", res_valid_a); end
    // A later find from a now-stopped core must be ignored.
    core_found = 2'b01; core_nonce = {32'h0, 32'h00001234}; tick(); core_found = 2'b00;
    n_checks++; if (res_valid_a !== 1'b1) begin n_fail++; $display("FAIL sof_valid got %b want 1", res_valid_a); end
    n_checks++; if (res_nonce_a !== 32'h4000ABCD) begin n_fail++; $display("FAIL sof_nonce got %h want 4000ABCD", res_nonce_a); end
    n_checks++; if (res_core_a !== 1'b1) begin n_fail++; $display("FAIL sof_core got %b want 1", res_core_a); end
    tick();
    n_checks++; if (res_valid_a !== 1'b1 || res_nonce_a !== 32'h4000ABCD) begin n_fail++; $display("FAIL sof_hold got %b/%h want 1/4000ABCD", res_valid_a, res_nonce_a); end
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL sof_busy_hold got %b want 1", busy_a); end
    res_ready = 1; tick();
    n_checks++; if (res_valid_a !== 1'b0) begin n_fail++; $display("FAIL sof_accept got %b want 0", res_valid_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL sof_busy got %b want 0", busy_a); end
    n_checks++; if (overflow_a !== 1'b0) begin n_fail++; $display("FAIL sof_ovf got %b want 0", overflow_a); end
    res_ready = 0;
  endtask

  task automatic test_overflow_rr();
    do_reset();
    start_job();
    core_found = 2'b11; core_nonce = {32'h40000020, 32'h00000010}; tick();
    core_found = 2'b01; core_nonce = {32'h0, 32'h00000011}; tick(); core_found = 2'b00;
    n_checks++; if (overflow_b !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow_b); end
    n_checks++; if (res_valid_b !== 1'b1 || res_nonce_b !== 32'h00000010 || res_core_b !== 1'b0) begin n_fail++; $display("FAIL ovf_first got %b/%h/%b want 1/00000010/0", res_valid_b, res_nonce_b, res_core_b); end
    tick();
    n_checks++; if (res_nonce_b !== 32'h00000010) begin n_fail++; $display("FAIL ovf_hold got %h want 00000010", res_nonce_b); end
    res_ready = 1; tick();
    n_checks++; if (res_valid_b !== 1'b1 || res_nonce_b !== 32'h40000020 || res_core_b !== 1'b1) begin n_fail++; $display("FAIL ovf_second got %b/%h/%b want 1/40000020/1", res_valid_b, res_nonce_b, res_core_b); end
    tick();
    n_checks++; if (res_valid_b !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped got %b/%h want 0", res_valid_b, res_nonce_b); end
    tick();
    n_checks++; if (res_valid_b !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped2 got %b/%h want 0", res_valid_b, res_nonce_b); end
    n_checks++; if (busy_b !== 1'b1) begin n_fail++; $display("FAIL ovf_keeps_running got %b want 1", busy_b); end
    res_ready = 0;
  endtask

  task automatic test_abort();
    do_reset();
    start_job();
    core_done = 2'b01; core_found = 2'b01; core_nonce = {32'h0, 32'h00000055}; tick();
    core_done = 2'b00; core_found = 2'b00;
    n_checks++; if (core_load_b !== 2'b01 || core_base_b[31:0] !== 32'h80000000) begin n_fail++; $display("FAIL ab_reload got %b/%h want 01/80000000", core_load_b, core_base_b[31:0]); end
    tick();
    n_checks++; if (res_valid_b !== 1'b1 || res_nonce_b !== 32'h00000055) begin n_fail++; $display("FAIL ab_found got %b/%h want 1/00000055", res_valid_b, res_nonce_b); end
    job_abort = 1; tick(); job_abort = 0;
    n_checks++; if (res_valid_b !== 1'b0) begin n_fail++; $display("FAIL ab_rvalid got %b want 0", res_valid_b); end
    n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL ab_busy got %b want 0", busy_b); end
    n_checks++; if (core_stop_b !== 2'b11) begin n_fail++; $display("FAIL ab_stop got %b want 11", core_stop_b); end
    job_start = 1; job_abort = 1; tick(); job_abort = 0; job_start = 0;
    n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL ab_wins got %b want 0", busy_b); end
    job_start = 1; tick(); job_start = 0;
    n_checks++; if (busy_b !== 1'b1 || core_load_b !== 2'b01 || core_base_b[31:0] !== 32'h0) begin n_fail++; $display("FAIL ab_restart got %b/%b/%h want 1/01/00000000", busy_b, core_load_b, core_base_b[31:0]); end
  endtask

  task automatic test_async_reset();
    do_reset();
    start_job();
    core_done = 2'b01; tick(); core_done = 2'b00;
    n_checks++; if (core_load_a !== 2'b01 || core_base_a[31:0] !== 32'h80000000) begin n_fail++; $display("FAIL ar_pre got %b/%h want 01/80000000", core_load_a, core_base_a[31:0]); end
    rst_n = 0;
    #2;
    n_checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL ar_busy got %b/%b want 0/0", busy_a, busy_b); end
    n_checks++; if (core_load_a !== 2'b00) begin n_fail++; $display("FAIL ar_load got %b want 00", core_load_a); end
    n_checks++; if (core_base_a !== 64'h0) begin n_fail++; $display("FAIL ar_base got %h want 0", core_base_a); end
    n_checks++; if (core_stop_a !== 2'b11 || core_stop_b !== 2'b11) begin n_fail++; $display("FAIL ar_stop got %b/%b want 11/11", core_stop_a, core_stop_b); end
    n_checks++; if (res_valid_a !== 1'b0 || exhausted_a !== 1'b0) begin n_fail++; $display("FAIL ar_misc got %b/%b want 0/0", res_valid_a, exhausted_a); end
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_reload_exhaust();
    test_stop_on_find();
    test_overflow_rr();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
